key_debounce: RTL

KEY_DEBOUNCE -- requirements
Module: key_debounce

---
 rtl/key_debounce.sv | 135 +++++++++++++
 1 files changed

// File: rtl/key_debounce.sv
// Four-channel push-button debouncer with one-hot press detection feeding a coded lock.
// Optional macro KEY_SYNC_EN inserts a two-flop synchronizer ahead of each debounce channel.
module key_debounce #(
  parameter int DB_CYCLES = 1000,
  parameter int CNT_W     = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       q,
  input  logic       u,
  input  logic       n,
  input  logic       b,
  input  logic       d,
  output logic       key_vld,
  output logic [1:0] key_code,
  output logic       key_err,
  output logic [3:0] key_state
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

  logic [3:0]            raw_s;
  logic [3:0]            samp_s;
  logic [3:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]            stable_q, stable_d;
  logic [3:0]            rise_q, rise_d;
  logic                  key_vld_q, key_vld_d;
  logic                  key_err_q, key_err_d;
  logic [1:0]            key_code_q, key_code_d;

  function automatic logic [2:0] popcnt4(input logic [3:0] v);
    popcnt4 = 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction

  function automatic logic [1:0] enc4(input logic [3:0] v);
    case (v)
      4'b0001: enc4 = 2'd0;
      4'b0010: enc4 = 2'd1;
      4'b0100: enc4 = 2'd2;
      4'b1000: enc4 = 2'd3;
      default: enc4 = 2'd0;
    endcase
  endfunction

  assign raw_s = {b, n, u, q};

`ifdef KEY_SYNC_EN
  logic [3:0] sync1_q, sync1_d;
  logic [3:0] sync2_q, sync2_d;

  // Two-stage metastability filter on the raw button levels.
  always_comb begin
    sync1_d = raw_s;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 4'b0000;
      sync2_q <= 4'b0000;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign samp_s = sync2_q;
`else
  assign samp_s = raw_s;
`endif

  // Debounce counters, stable levels and press/conflict detection.
  always_comb begin
    cnt_d      = cnt_q;
    stable_d   = stable_q;
    key_vld_d  = 1'b0;
    key_err_d  = 1'b0;
    key_code_d = key_code_q;
    for (int k = 0; k < 4; k++) begin
      if (!d) begin
        cnt_d[k]    = '0;
        stable_d[k] = 1'b0;
      end else if (samp_s[k] == stable_q[k]) begin
        cnt_d[k] = '0;
      end else if (cnt_q[k] == CNT_MAX) begin
        cnt_d[k]    = '0;
        stable_d[k] = ~stable_q[k];
      end else begin
        cnt_d[k] = cnt_q[k] + CNT_W'(1);
      end
    end
    // stable_d is forced low while disarmed, so no rise can be recorded then.
    rise_d = stable_d & ~stable_q;
    if (d) begin
      case (popcnt4(rise_q))
        3'd0: begin
          key_vld_d = 1'b0;
        end
        3'd1: begin
          key_vld_d  = 1'b1;
          key_code_d = enc4(rise_q);
        end
        default: begin
          key_err_d = 1'b1;
        end
      endcase
    end else begin
      key_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      stable_q   <= 4'b0000;
      rise_q     <= 4'b0000;
      key_vld_q  <= 1'b0;
      key_err_q  <= 1'b0;
      key_code_q <= 2'd0;
    end else begin
      cnt_q      <= cnt_d;
      stable_q   <= stable_d;
      rise_q     <= rise_d;
      key_vld_q  <= key_vld_d;
      key_err_q  <= key_err_d;
      key_code_q <= key_code_d;
    end
  end

  assign key_vld   = key_vld_q;
  assign key_err   = key_err_q;
  assign key_code  = key_code_q;
  assign key_state = stable_q;

endmodule
